// File: rtl/tone_period_meter.sv
// Measures rise-to-rise period and high time of an asynchronous square-wave tone,
// flags loss of tone and reports lock once successive periods agree within TOL.
module tone_period_meter #(
    parameter int unsigned      CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = 28'd50_000_000,
    parameter logic [CNT_W-1:0] TOL     = 28'd2,
    parameter int unsigned      LOCK_N  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             no_tone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT   = TIMEOUT - CNT_ONE;
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [3:0]       r_match_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_no_tone;

    logic             w_rise;
    logic             w_at_limit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_diff;
    logic             w_match;
    logic [3:0]       w_mc_inc;

    // Tone synchronizer and edge-history flop; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= tone_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Edge detect, timeout compare and lock arithmetic (|diff| without wrap).
    always_comb begin
        w_rise     = r_s2 & ~r_prev;
        w_at_limit = (r_cnt == LIMIT);
        w_cnt_inc  = r_cnt + CNT_ONE;
        if (w_cnt_inc >= r_period) begin
            w_diff = w_cnt_inc - r_period;
        end else begin
            w_diff = r_period - w_cnt_inc;
        end
        w_match = (w_diff <= TOL);
        if (r_match_cnt >= LOCK_C) begin
            w_mc_inc = LOCK_C;
        end else begin
            w_mc_inc = r_match_cnt + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a rise on the timeout cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEAS;
                    end else begin
                        w_state_nxt = ST_ARM;
                    end
                end
                ST_MEAS: begin
                    if (!w_rise && w_at_limit) begin
                        w_state_nxt = ST_ARM;
                    end else begin
                        w_state_nxt = ST_MEAS;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counters, measurement outputs and lock/loss-of-tone flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_hcnt         <= '0;
            r_match_cnt    <= 4'd0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_no_tone      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!enable || (r_state == ST_IDLE)) begin
                r_cnt       <= '0;
                r_hcnt      <= '0;
                r_match_cnt <= 4'd0;
                r_locked    <= 1'b0;
                r_no_tone   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ARM: begin
                        if (w_rise) begin
                            r_cnt  <= '0;
                            r_hcnt <= CNT_ONE;
                        end else if (w_at_limit) begin
                            r_no_tone <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_MEAS: begin
                        if (w_rise) begin
                            r_period       <= w_cnt_inc;
                            r_high_time    <= r_hcnt;
                            r_period_valid <= 1'b1;
                            r_cnt          <= '0;
                            r_hcnt         <= CNT_ONE;
                            r_no_tone      <= 1'b0;
                            if (w_match) begin
                                r_match_cnt <= w_mc_inc;
                                if (w_mc_inc == LOCK_C) begin
                                    r_locked <= 1'b1;
                                end else begin
                                    r_locked <= r_locked;
                                end
                            end else begin
                                r_match_cnt <= 4'd0;
                                r_locked    <= 1'b0;
                            end
                        end else if (w_at_limit) begin
                            r_no_tone   <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_cnt <= 4'd0;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_hcnt <= r_hcnt + CNT_W'(r_s2);
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign no_tone      = r_no_tone;

endmodule

// File: tb/tb_tone_period_meter.sv
// Scoreboard bench for tone_period_meter: each driven rise that closes a period
// queues the expected period/high time/lock/arrival cycle, checked on period_valid.
module tb_tone_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tone_in;
    logic [27:0] period;
    logic [27:0] high_time;
    logic        period_valid;
    logic        locked;
    logic        no_tone;

    tone_period_meter #(
        .TIMEOUT(28'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tone_in     (tone_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .no_tone     (no_tone)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        bit          lk;
        int unsigned cy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_vectors     = 0;
    int n_miscompares = 0;

    int unsigned prev_n    = 0;
    int unsigned prev_h    = 0;
    int unsigned m_old     = 0;
    int unsigned m_cnt     = 0;
    bit          m_lock    = 1'b0;
    bit          meas_open = 1'b0;
    int unsigned last_rise = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference lock model: applied once per measured period, in drive order.
    task automatic push_update();
        int unsigned d;
        d = (prev_n >= m_old) ? (prev_n - m_old) : (m_old - prev_n);
        if (d <= 2) begin
            m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
            if (m_cnt == 4) m_lock = 1'b1;
        end else begin
            m_cnt  = 0;
            m_lock = 1'b0;
        end
        m_old = prev_n;
        q.push_back('{per: prev_n, hi: prev_h, lk: m_lock, cy: cyc + 3});
    endtask

    task automatic tone_period(input int unsigned n, input int unsigned h);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tone_in = (i < h);
            if (i == 0) begin
                last_rise = cyc;
                if (meas_open) push_update();
                prev_n    = n;
                prev_h    = h;
                meas_open = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tone_in = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_period"}, 32'(period), 32'd0);
        check_val({tag, "_high"}, 32'(high_time), 32'd0);
        check_val({tag, "_valid"}, 32'(period_valid), 32'd0);
        check_val({tag, "_locked"}, 32'(locked), 32'd0);
        check_val({tag, "_no_tone"}, 32'(no_tone), 32'd0);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            if (q.size() == 0) begin
                check_val("spurious_valid", 32'(period_valid), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check_val("period", 32'(period), mon_e.per);
                check_val("high_time", 32'(high_time), mon_e.hi);
                check_val("locked_at_update", 32'(locked), 32'(mon_e.lk));
                check_val("no_tone_at_update", 32'(no_tone), 32'd0);
                check_val("valid_cycle", cyc, mon_e.cy);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst    = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Divisor 16: lock on the 4th matching update.
        repeat (8) tone_period(16, 8);
        check_val("t1_locked", 32'(locked), 32'd1);
        check_val("t1_period", 32'(period), 32'd16);
        check_val("t1_no_tone", 32'(no_tone), 32'd0);

        // Switch to divisor 32.
        repeat (6) tone_period(32, 16);
        check_val("t2_locked", 32'(locked), 32'd1);
        check_val("t2_period", 32'(period), 32'd32);

        // Relock at 16, then stop the tone.
        repeat (6) tone_period(16, 8);
        check_val("t3_relocked", 32'(locked), 32'd1);
        repeat (last_rise + 102 - cyc) @(posedge clk);
        #1;
        check_val("t3_no_tone_early", 32'(no_tone), 32'd0);
        @(posedge clk);
        #1;
        check_val("t3_no_tone", 32'(no_tone), 32'd1);
        check_val("t3_unlocked", 32'(locked), 32'd0);
        check_val("t3_period_held", 32'(period), 32'd16);
        meas_open = 1'b0;
        m_lock    = 1'b0;
        m_cnt     = 0;
        tone_period(16, 8);
        check_val("t3_no_tone_armed", 32'(no_tone), 32'd1);
        tone_period(16, 8);
        check_val("t3_no_tone_cleared", 32'(no_tone), 32'd0);

        // Jittery periods within tolerance, then an outlier.
        repeat (6) tone_period(20, 10);
        tone_period(21, 10);
        tone_period(22, 10);
        tone_period(20, 10);
        tone_period(21, 10);
        tone_period(22, 10);
        tone_period(20, 10);
        check_val("t4_lock_holds", 32'(locked), 32'd1);
        tone_period(25, 12);
        tone_period(20, 10);
        check_val("t4_unlocked", 32'(locked), 32'd0);
        tone_period(20, 10);

        // Synchronous reset mid-period.
        tone_period(12, 8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("t5_rst");
        meas_open = 1'b0;
        m_old     = 0;
        m_cnt     = 0;
        m_lock    = 1'b0;
        idle_cycles(2);
        repeat (7) tone_period(16, 8);
        check_val("t5_relocked", 32'(locked), 32'd1);

        // Drop enable for 5 cycles while locked.
        tone_period(10, 8);
        @(posedge clk);
        #1;
        enable = 1'b0;
        meas_open = 1'b0;
        m_cnt     = 0;
        m_lock    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("t6_idle_locked", 32'(locked), 32'd0);
        check_val("t6_idle_period", 32'(period), 32'd16);
        check_val("t6_idle_no_tone", 32'(no_tone), 32'd0);
        enable = 1'b1;
        repeat (3) tone_period(16, 8);

        idle_cycles(40);
        check_val("sb_drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
